gpreg_bank_avmm: RTL and testbench

//  Parametrised successor of the single general-purpose export register: an Avalon-MM slave

---
 rtl/gpreg_pkg.sv | 31 +++
 rtl/gpreg_in_sync.sv | 46 ++++
 rtl/gpreg_bank_avmm.sv | 151 +++++++++++++++
 tb/tb_gpreg_bank_avmm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpreg_pkg.sv
// Shared definitions for the general-purpose register bank: write-op encodings,
// register index offsets above the output registers, and the byte-lane merge helper.
package gpreg_pkg;

    // Write operations carried in the upper two address bits
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;
    localparam logic [1:0] OP_TGL   = 2'b11;

    // Index offsets relative to N_REGS for the non-output registers
    localparam int IDX_IN   = 0;  // synchronised input word, read-only
    localparam int IDX_STAT = 1;  // rising-edge status, write-one-to-clear
    localparam int IDX_MASK = 2;  // interrupt mask, read/write
    localparam int IDX_NUM_EXTRA = 3;

    // Apply one write operation to a single byte lane
    function automatic logic [7:0] merge_byte(input logic [1:0] op,
                                              input logic [7:0] cur,
                                              input logic [7:0] wd);
        logic [7:0] res;
        case (op)
            OP_SET:  res = cur | wd;
            OP_CLR:  res = cur & ~wd;
            OP_TGL:  res = cur ^ wd;
            default: res = wd;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gpreg_in_sync.sv
// Multi-flop synchroniser for the asynchronous input word. When GPREG_IRQ_EN is
// defined a history flop follows the chain and a one-cycle rise pulse is produced.
module gpreg_in_sync
    import gpreg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] gp_i,
    output logic [DATA_W-1:0] sync_o
`ifdef GPREG_IRQ_EN
    ,
    output logic [DATA_W-1:0] rise_o
`endif
);

    logic [DATA_W-1:0] sync_q [SYNC_STAGES];

    // Shift the raw input through the synchroniser chain
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gp_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

`ifdef GPREG_IRQ_EN
    logic [DATA_W-1:0] hist_q;

    // Remember the previous synchronised word to detect 0->1 transitions
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hist_q <= '0;
        else         hist_q <= sync_o;
    end

    assign rise_o = sync_o & ~hist_q;
`endif

endmodule

// File: rtl/gpreg_bank_avmm.sv
// Avalon-MM general-purpose register bank: N_REGS exported output words with
// write/set/clear/toggle aliases, a synchronised input word and, when the macro
// GPREG_IRQ_EN is defined, rising-edge status, interrupt mask and a level irq.
// Address is {op[1:0], idx[IDX_W-1:0]}; read data appears one cycle after avs_read.
module gpreg_bank_avmm
    import gpreg_pkg::*;
#(
    parameter int                N_REGS      = 4,
    parameter int                DATA_W      = 32,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    localparam int               IDX_W       = $clog2(N_REGS + IDX_NUM_EXTRA),
    localparam int               BE_W        = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [IDX_W+1:0]         avs_address,
    input  logic                     avs_write,
    input  logic [DATA_W-1:0]        avs_writedata,
    input  logic [BE_W-1:0]          avs_byteenable,
    input  logic                     avs_read,
    output logic [DATA_W-1:0]        avs_readdata,
    output logic [N_REGS*DATA_W-1:0] gp_out,
    input  logic [DATA_W-1:0]        gp_in,
    output logic                     irq
);

    localparam logic [IDX_W-1:0] IDX_IN_A = IDX_W'(N_REGS + IDX_IN);

    logic [1:0]        op;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] sync_w;

    assign op  = avs_address[IDX_W +: 2];
    assign idx = avs_address[IDX_W-1:0];

`ifdef GPREG_IRQ_EN
    localparam logic [IDX_W-1:0] IDX_STAT_A = IDX_W'(N_REGS + IDX_STAT);
    localparam logic [IDX_W-1:0] IDX_MASK_A = IDX_W'(N_REGS + IDX_MASK);

    logic [DATA_W-1:0] rise_w, be_mask, w1c;
    logic [DATA_W-1:0] stat_q, stat_d, mask_q, mask_d;
    logic              irq_q;

    gpreg_in_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .gp_i   (gp_in),
        .sync_o (sync_w),
        .rise_o (rise_w)
    );

    // Next status and mask: a coincident rise wins over W1C on the same bit
    always_comb begin
        for (int b = 0; b < BE_W; b++) be_mask[b*8 +: 8] = {8{avs_byteenable[b]}};
        w1c    = (avs_write && idx == IDX_STAT_A) ? (avs_writedata & be_mask) : '0;
        stat_d = (stat_q & ~w1c) | rise_w;
        mask_d = mask_q;
        if (avs_write && idx == IDX_MASK_A) begin
            mask_d = (mask_q & ~be_mask) | (avs_writedata & be_mask);
        end
    end

    // Status, mask and registered interrupt level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            mask_q <= mask_d;
            irq_q  <= |(stat_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    gpreg_in_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .gp_i   (gp_in),
        .sync_o (sync_w)
    );

    assign irq = 1'b0;
`endif

    // Output register next state: per-lane merge on the addressed register
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (avs_write) begin
            for (int k = 0; k < N_REGS; k++) begin
                if (idx == IDX_W'(k)) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (avs_byteenable[b]) begin
                            regs_d[k][b*8 +: 8] = merge_byte(op, regs_q[k][b*8 +: 8],
                                                             avs_writedata[b*8 +: 8]);
                        end
                    end
                end
            end
        end
    end

    // Output register bank
    // NOTE: the bank is small and must come up at RESET_VAL, so each word is reset explicitly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_REGS; k++) regs_q[k] <= RESET_VAL;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read mux over pre-write state; op bits are ignored for reads
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (idx == IDX_W'(k)) rdata_d = regs_q[k];
        end
        if (idx == IDX_IN_A) rdata_d = sync_w;
`ifdef GPREG_IRQ_EN
        if (idx == IDX_STAT_A) rdata_d = stat_q;
        if (idx == IDX_MASK_A) rdata_d = mask_q;
`endif
    end

    // Read data register: loads on avs_read, holds otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      rdata_q <= '0;
        else if (avs_read) rdata_q <= rdata_d;
    end

    assign avs_readdata = rdata_q;

    for (genvar k = 0; k < N_REGS; k++) begin : g_out
        assign gp_out[k*DATA_W +: DATA_W] = regs_q[k];
    end

endmodule

// File: tb/tb_gpreg_bank_avmm.sv
// Self-checking bench for gpreg_bank_avmm: directed scenarios plus randomized
// traffic against a word-level reference model. Read responses go through a
// scoreboard queue drained by an independent monitor. Honours GPREG_IRQ_EN.
module tb_gpreg_bank_avmm;

    localparam int N_REGS = 4;
    localparam int DATA_W = 32;
    localparam int S      = 2;
    localparam int IDX_W  = 3;
    localparam int BE_W   = 4;
    localparam logic [DATA_W-1:0] RST_V = 32'h0;
`ifdef GPREG_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [IDX_W+1:0]         avs_address;
    logic                     avs_write;
    logic [DATA_W-1:0]        avs_writedata;
    logic [BE_W-1:0]          avs_byteenable;
    logic                     avs_read;
    logic [DATA_W-1:0]        avs_readdata;
    logic [N_REGS*DATA_W-1:0] gp_out;
    logic [DATA_W-1:0]        gp_in;
    logic                     irq;

    gpreg_bank_avmm #(
        .N_REGS      (N_REGS),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (S),
        .RESET_VAL   (RST_V)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_byteenable (avs_byteenable),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .gp_out         (gp_out),
        .gp_in          (gp_in),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] m_regs [N_REGS];
    logic [DATA_W-1:0] m_stat, m_mask, m_last_rd;
    logic [DATA_W-1:0] gin_q [$];   // gp_in value presented before each clock edge
    logic [DATA_W-1:0] exp_q [$];   // scoreboard of expected read data

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_REGS; k++) m_regs[k] = RST_V;
        m_stat    = '0;
        m_mask    = '0;
        m_last_rd = '0;
        exp_q.delete();
        gin_q.delete();
        for (int i = 0; i <= S; i++) gin_q.push_back('0);
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [IDX_W-1:0] idx,
                                                     input logic [DATA_W-1:0] sync_v);
        int i;
        i = int'(idx);
        if (i < N_REGS)                    return m_regs[i];
        if (i == N_REGS)                   return sync_v;
        if (IRQ_EN && i == N_REGS + 1)     return m_stat;
        if (IRQ_EN && i == N_REGS + 2)     return m_mask;
        return '0;
    endfunction

    // One bus cycle: drive at the falling edge, advance one rising edge, then
    // compare exported outputs at the next falling edge.
    task automatic do_cycle(input logic wr, input logic rd, input logic [1:0] op,
                            input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d,
                            input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] sync_v, hist_v, rise, bm, dm, w1c;
        logic              exp_irq;
        int                i;
        avs_write      = wr;
        avs_read       = rd;
        avs_address    = {op, idx};
        avs_writedata  = d;
        avs_byteenable = be;
        gin_q.push_back(gp_in);
        sync_v  = gin_q[gin_q.size()-1-S];
        hist_v  = gin_q[gin_q.size()-2-S];
        rise    = IRQ_EN ? (sync_v & ~hist_v) : '0;
        exp_irq = IRQ_EN && ((m_stat & m_mask) != '0);
        if (rd) exp_q.push_back(model_read(idx, sync_v));
        for (int b = 0; b < BE_W; b++) bm[b*8 +: 8] = {8{be[b]}};
        dm  = d & bm;
        w1c = '0;
        i   = int'(idx);
        if (wr) begin
            if (i < N_REGS) begin
                case (op)
                    2'b00: m_regs[i] = (m_regs[i] & ~bm) | dm;
                    2'b01: m_regs[i] = m_regs[i] | dm;
                    2'b10: m_regs[i] = m_regs[i] & ~dm;
                    default: m_regs[i] = m_regs[i] ^ dm;
                endcase
            end else if (IRQ_EN && i == N_REGS + 1) begin
                w1c = dm;
            end else if (IRQ_EN && i == N_REGS + 2) begin
                m_mask = (m_mask & ~bm) | dm;
            end
        end
        m_stat = (m_stat & ~w1c) | rise;
        while (gin_q.size() > S + 2) void'(gin_q.pop_front());
        @(negedge clk);
        for (int k = 0; k < N_REGS; k++) check($sformatf("gp_out[%0d]", k),
                                               gp_out[k*DATA_W +: DATA_W], m_regs[k]);
        check("irq", {31'b0, irq}, {31'b0, exp_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 2'b00, '0, '0, '0);
    endtask

    task automatic wr(input logic [1:0] op, input int idx, input logic [DATA_W-1:0] d,
                      input logic [BE_W-1:0] be);
        do_cycle(1'b1, 1'b0, op, IDX_W'(idx), d, be);
    endtask

    task automatic rd(input int idx);
        do_cycle(1'b0, 1'b1, 2'b00, IDX_W'(idx), '0, '0);
    endtask

    // Monitor: a read accepted at a rising edge is compared at the next falling edge
    initial begin
        logic pend;
        logic [DATA_W-1:0] e;
        forever begin
            @(posedge clk);
            pend = avs_read && reset_n;
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL readdata: response with empty scoreboard, got %h", avs_readdata);
                end else begin
                    e = exp_q.pop_front();
                    check("readdata", avs_readdata, e);
                    m_last_rd = e;
                end
            end else if (reset_n) begin
                check("readdata_hold", avs_readdata, m_last_rd);
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        avs_write = 1'b0; avs_read = 1'b0; avs_address = '0;
        avs_writedata = '0; avs_byteenable = '0; gp_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_readdata", avs_readdata, '0);
        check("rst_irq", {31'b0, irq}, '0);
        reset_n = 1'b1;

        // 1: reset state and first read
        rd(0);
        idle(1);
        // 2: full write and read back
        wr(2'b00, 0, 32'h0000_00A5, 4'hF);
        rd(0);
        // 3: set / clear / toggle aliases
        wr(2'b01, 1, 32'h0000_000F, 4'hF);
        wr(2'b10, 1, 32'h0000_0003, 4'hF);
        rd(1);
        wr(2'b11, 1, 32'h0000_00FF, 4'h1);
        rd(1);
        // 4: single byte lane write
        wr(2'b00, 0, 32'hFFFF_FFFF, 4'h2);
        rd(0);
        // read + write same index returns pre-write value
        do_cycle(1'b1, 1'b1, 2'b00, 3'd2, 32'h1234_5678, 4'hF);
        rd(2);
        // 5: input edge capture, mask, irq, W1C, W1C racing a new rise
        gp_in = 32'h0000_0008;
        idle(S + 1);
        rd(N_REGS + 1);
        rd(N_REGS);
        wr(2'b11, N_REGS + 2, 32'h0000_0008, 4'hF);  // op ignored for mask
        idle(2);
        wr(2'b00, N_REGS + 1, 32'h0000_0008, 4'hF);
        idle(2);
        rd(N_REGS + 1);
        gp_in = '0;
        idle(S + 2);
        gp_in = 32'h0000_0008;
        idle(S);
        wr(2'b01, N_REGS + 1, 32'h0000_0008, 4'hF);  // coincides with the rise
        rd(N_REGS + 1);
        idle(2);
        // writes to read-only / unmapped indices ignored, unmapped reads 0
        wr(2'b00, N_REGS, 32'hDEAD_BEEF, 4'hF);
        wr(2'b00, N_REGS + 3, 32'hDEAD_BEEF, 4'hF);
        rd(N_REGS + 3);
        rd(N_REGS);

        // Randomized traffic, including input word changes
        for (int n = 0; n < 400; n++) begin
            if (n % 7 == 0) gp_in = $urandom;
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), IDX_W'($urandom_range(0, 7)),
                     $urandom, BE_W'($urandom_range(0, 15)));
        end

        // 6: asynchronous reset in the middle of a write burst
        wr(2'b00, 3, 32'hCAFE_F00D, 4'hF);
        avs_write = 1'b1; avs_read = 1'b0;
        avs_address = {2'b01, 3'd3}; avs_writedata = 32'hFFFF_FFFF; avs_byteenable = 4'hF;
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < N_REGS; k++) check($sformatf("async_rst_gp_out[%0d]", k),
                                               gp_out[k*DATA_W +: DATA_W], RST_V);
        check("async_rst_irq", {31'b0, irq}, '0);
        check("async_rst_readdata", avs_readdata, '0);
        avs_write = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(N_REGS + 3);
        rd(3);
        rd(N_REGS + 1);
        rd(N_REGS + 2);
        idle(S + 3);
        rd(N_REGS);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
